// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared stack-page constants and sequencer/decoder enums
package stack_pkg;

    // High address byte of every 6502 stack access.
    localparam logic [7:0] STACK_PAGE = 8'h01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PUSH,
        ST_PULL_INC,
        ST_PULL_RD,
        ST_PULL_CAP,
        ST_DONE
    } seq_state_t;

    // Direction of a stack command, also used by the control unit's decoder.
    typedef enum logic {
        OP_PUSH,
        OP_PULL
    } stack_op_t;

endpackage

// File: rtl/stack_sequencer.sv
// rtl/stack_sequencer.sv - multi-byte push/pull sequencer for the 6502 stack page
module stack_sequencer #(
    parameter int         MAX_BYTES  = 3,
    parameter logic [7:0] STACK_PAGE = stack_pkg::STACK_PAGE,
    parameter int         CNT_W      = $clog2(MAX_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_pull,
    input  logic [CNT_W-1:0]       cmd_count,
    input  logic [8*MAX_BYTES-1:0] push_data,
    input  logic [7:0]             sp_in,
    output logic                   sp_inc,
    output logic                   sp_dec,
    output logic [15:0]            mem_addr,
    output logic [7:0]             mem_wdata,
    output logic                   mem_we,
    output logic                   mem_re,
    input  logic [7:0]             mem_rdata,
    output logic [8*MAX_BYTES-1:0] pull_data,
    output logic                   busy,
    output logic                   done
);
    import stack_pkg::*;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    seq_state_t             state;
    logic [CNT_W-1:0]       byte_idx;
    logic [CNT_W-1:0]       count_q;
    logic [8*MAX_BYTES-1:0] push_buf;
    logic [CNT_W-1:0]       count_clamped;
    stack_op_t              cmd_op;
    logic                   last_byte;

    assign count_clamped = (cmd_count > MAX_CNT) ? MAX_CNT : cmd_count;
    assign cmd_op        = cmd_pull ? OP_PULL : OP_PUSH;
    assign last_byte     = ((byte_idx + ONE) == count_q);

    // Strobes and status are pure decodes of the state register, so an
    // asynchronous reset drops every strobe immediately.
    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign mem_we    = (state == ST_PUSH);
    assign sp_dec    = (state == ST_PUSH);
    assign sp_inc    = (state == ST_PULL_INC);
    assign mem_re    = (state == ST_PULL_RD);

    // Address is the live SP in the stack page; it never carries into the high byte.
    assign mem_addr = (mem_we || mem_re) ? {STACK_PAGE, sp_in} : 16'h0000;

    // Select the byte currently being pushed from the latched buffer.
    always_comb begin
        mem_wdata = 8'h00;
        if (state == ST_PUSH) begin
            for (int i = 0; i < MAX_BYTES; i++) begin
                if (byte_idx == CNT_W'(i)) begin
                    mem_wdata = push_buf[8*i +: 8];
                end
            end
        end
    end

    // Command FSM: accept, walk the byte index, capture pulled bytes, pulse done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            byte_idx  <= '0;
            count_q   <= '0;
            push_buf  <= '0;
            pull_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        push_buf <= push_data;
                        count_q  <= count_clamped;
                        byte_idx <= '0;
                        if (cmd_op == OP_PULL) begin
                            pull_data <= '0;
                        end
                        if (count_clamped == '0) begin
                            state <= ST_DONE;
                        end else if (cmd_op == OP_PULL) begin
                            state <= ST_PULL_INC;
                        end else begin
                            state <= ST_PUSH;
                        end
                    end
                end
                ST_PUSH: begin
                    byte_idx <= byte_idx + ONE;
                    if (last_byte) begin
                        state <= ST_DONE;
                    end
                end
                ST_PULL_INC: begin
                    state <= ST_PULL_RD;
                end
                ST_PULL_RD: begin
                    state <= ST_PULL_CAP;
                end
                ST_PULL_CAP: begin
                    for (int i = 0; i < MAX_BYTES; i++) begin
                        if (byte_idx == CNT_W'(i)) begin
                            pull_data[8*i +: 8] <= mem_rdata;
                        end
                    end
                    byte_idx <= byte_idx + ONE;
                    state    <= last_byte ? ST_DONE : ST_PULL_INC;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_sequencer.sv
// tb/tb_stack_sequencer.sv - self-checking bench for stack_sequencer
module tb_stack_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_pull;
    logic [1:0]  cmd_count;
    logic [23:0] push_data;
    logic [7:0]  sp;
    logic        sp_inc;
    logic        sp_dec;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_rdata;
    logic [23:0] pull_data;
    logic        busy;
    logic        done;

    logic        sp_load;
    logic [7:0]  sp_load_val;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [256];
    logic [7:0]  ref_mem [256];
    logic [23:0] ref_pd;
    logic [23:0] wlog [$];
    logic [15:0] rlog [$];

    always #5 clk = ~clk;

    stack_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_pull  (cmd_pull),
        .cmd_count (cmd_count),
        .push_data (push_data),
        .sp_in     (sp),
        .sp_inc    (sp_inc),
        .sp_dec    (sp_dec),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .pull_data (pull_data),
        .busy      (busy),
        .done      (done)
    );

    // Behavioural stack pointer: load wins, then inc/dec, wraps mod 256.
    always @(posedge clk) begin
        if (sp_load) sp <= sp_load_val;
        else if (sp_inc) sp <= sp + 8'd1;
        else if (sp_dec) sp <= sp - 8'd1;
    end

    // Memory slave with a one-cycle read latency, logging every access.
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[7:0]] <= mem_wdata;
            wlog.push_back({mem_addr, mem_wdata});
        end
        if (mem_re) begin
            mem_rdata <= mem[mem_addr[7:0]];
            rlog.push_back(mem_addr);
        end
    end

    // Load must never coincide with an active command.
    always @(posedge clk) begin
        if (sp_load && busy) begin
            errors++;
            $display("FAIL load_while_busy: load=%b busy=%b required busy=0", sp_load, busy);
        end
    end

    // Per-cycle strobe and status invariants.
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if ((sp_inc && sp_dec) || (mem_we && mem_re) ||
                ((cmd_ready || done) && (sp_inc || sp_dec || mem_we || mem_re)) ||
                (!(mem_we || mem_re) && mem_addr != 16'h0000) ||
                ((mem_we || mem_re) && mem_addr[15:8] != 8'h01) ||
                (busy == cmd_ready)) begin
                errors++;
                $display("FAIL invariant: inc=%b dec=%b we=%b re=%b rdy=%b busy=%b done=%b addr=%h",
                         sp_inc, sp_dec, mem_we, mem_re, cmd_ready, busy, done, mem_addr);
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic set_sp(input logic [7:0] v);
        @(negedge clk);
        sp_load     = 1'b1;
        sp_load_val = v;
        @(negedge clk);
        sp_load     = 1'b0;
    endtask

    // Issue a command and count cycles from accept to the done pulse.
    task automatic do_cmd(input logic pull, input logic [1:0] cnt, input logic [23:0] data,
                          input bit release_valid, output int cyc, output int wait_cycles,
                          output bit busy_ok);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_pull  = pull;
        cmd_count = cnt;
        push_data = data;
        wait_cycles = 0;
        while (!cmd_ready && wait_cycles < 50) begin
            @(negedge clk);
            wait_cycles++;
        end
        @(posedge clk);
        cyc = -1;
        busy_ok = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (cmd_ready) busy_ok = 1'b0;
            if (c == 1 && release_valid) cmd_valid = 1'b0;
            if (done) begin
                cyc = c;
                break;
            end
        end
    endtask

    // Reference model: derive expected bus traffic, SP and pulled bytes from the rules.
    task automatic exec_and_check(input string nm, input logic pull, input logic [1:0] cnt,
                                  input logic [23:0] data, input bit release_valid,
                                  output int cyc);
        logic [23:0] exp_w [$];
        logic [15:0] exp_r [$];
        logic [7:0]  s0, a, exp_sp;
        int n, exp_cyc, wc;
        bit bok;
        n  = int'(cnt);
        s0 = sp;
        if (pull) begin
            ref_pd = 24'h0;
            for (int i = 0; i < n; i++) begin
                a = s0 + 8'(i + 1);
                exp_r.push_back({8'h01, a});
                ref_pd[8*i +: 8] = ref_mem[a];
            end
            exp_sp  = s0 + 8'(n);
            exp_cyc = (n == 0) ? 1 : 3 * n + 1;
        end else begin
            for (int i = 0; i < n; i++) begin
                a = s0 - 8'(i);
                exp_w.push_back({8'h01, a, data[8*i +: 8]});
                ref_mem[a] = data[8*i +: 8];
            end
            exp_sp  = s0 - 8'(n);
            exp_cyc = n + 1;
        end
        wlog.delete();
        rlog.delete();
        do_cmd(pull, cnt, data, release_valid, cyc, wc, bok);
        check({nm, ".cycles"}, cyc, exp_cyc);
        check({nm, ".ready_low"}, {31'd0, bok}, 32'd1);
        check({nm, ".sp"}, {24'd0, sp}, {24'd0, exp_sp});
        check({nm, ".pull_data"}, {8'd0, pull_data}, {8'd0, ref_pd});
        check({nm, ".nwrites"}, wlog.size(), exp_w.size());
        check({nm, ".nreads"}, rlog.size(), exp_r.size());
        for (int i = 0; i < exp_w.size() && i < wlog.size(); i++)
            check({nm, ".write"}, {8'd0, wlog[i]}, {8'd0, exp_w[i]});
        for (int i = 0; i < exp_r.size() && i < rlog.size(); i++)
            check({nm, ".read"}, {16'd0, rlog[i]}, {16'd0, exp_r[i]});
    endtask

    typedef struct {
        string       name;
        logic [7:0]  sp0;
        logic        pull;
        logic [1:0]  cnt;
        logic [23:0] data;
        int          cyc;
        logic [7:0]  sp_end;
        logic [23:0] pd;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int cyc, wc;
        bit bok;

        vecs[0] = '{"push3",  8'hFF, 1'b0, 2'd3, 24'h563412, 4,  8'hFC, 24'h000000};
        vecs[1] = '{"pull3",  8'hFC, 1'b1, 2'd3, 24'h000000, 10, 8'hFF, 24'h123456};
        vecs[2] = '{"wrap_push2", 8'h00, 1'b0, 2'd2, 24'h00BBAA, 3, 8'hFE, 24'h123456};
        vecs[3] = '{"wrap_pull1", 8'hFF, 1'b1, 2'd1, 24'h000000, 4, 8'h00, 24'h0000AA};
        vecs[4] = '{"push0",  8'h40, 1'b0, 2'd0, 24'hDEADBE, 1,  8'h40, 24'h0000AA};
        vecs[5] = '{"pull0",  8'h40, 1'b1, 2'd0, 24'h000000, 1,  8'h40, 24'h000000};

        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'(i) ^ 8'h5A;
            ref_mem[i] = 8'(i) ^ 8'h5A;
        end
        ref_pd      = 24'h0;
        reset       = 1'b1;
        cmd_valid   = 1'b0;
        cmd_pull    = 1'b0;
        cmd_count   = 2'd0;
        push_data   = 24'h0;
        sp_load     = 1'b1;
        sp_load_val = 8'hFF;
        mem_rdata   = 8'h00;
        repeat (3) @(negedge clk);
        sp_load = 1'b0;
        reset   = 1'b0;

        check("reset.ready", {31'd0, cmd_ready}, 32'd1);
        check("reset.busy", {31'd0, busy}, 32'd0);
        check("reset.done", {31'd0, done}, 32'd0);
        check("reset.pull_data", {8'd0, pull_data}, 32'd0);
        check("reset.strobes", {28'd0, sp_inc, sp_dec, mem_we, mem_re}, 32'd0);
        check("reset.addr", {16'd0, mem_addr}, 32'd0);

        // Directed table from the scenarios, chained through the same memory.
        for (int i = 0; i < 6; i++) begin
            set_sp(vecs[i].sp0);
            exec_and_check(vecs[i].name, vecs[i].pull, vecs[i].cnt, vecs[i].data, 1'b1, cyc);
            check({vecs[i].name, ".tbl_cycles"}, cyc, vecs[i].cyc);
            check({vecs[i].name, ".tbl_sp"}, {24'd0, sp}, {24'd0, vecs[i].sp_end});
            check({vecs[i].name, ".tbl_pd"}, {8'd0, pull_data}, {8'd0, vecs[i].pd});
        end
        check("wrap.mem0100", {24'd0, mem[8'h00]}, 32'h000000AA);
        check("wrap.mem01FF", {24'd0, mem[8'hFF]}, 32'h000000BB);

        // Reset during the second cycle of a 3-byte push.
        set_sp(8'hFF);
        wlog.delete();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_pull = 1'b0; cmd_count = 2'd3; push_data = 24'hC3B2A1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_mid.strobes", {28'd0, sp_inc, sp_dec, mem_we, mem_re}, 32'd0);
        check("rst_mid.busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid.ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_mid.nwrites", wlog.size(), 1);
        if (wlog.size() > 0) check("rst_mid.write", {8'd0, wlog[0]}, 32'h0001FFA1);
        check("rst_mid.sp", {24'd0, sp}, 32'h000000FE);
        check("rst_mid.pull_data", {8'd0, pull_data}, 32'd0);
        ref_mem[8'hFF] = 8'hA1;
        ref_pd = 24'h0;

        // Held cmd_valid across two commands: second accepted the cycle after done.
        set_sp(8'h80);
        exec_and_check("queued_push", 1'b0, 2'd1, 24'h000077, 1'b0, cyc);
        wlog.delete();
        rlog.delete();
        do_cmd(1'b1, 2'd1, 24'h0, 1'b1, cyc, wc, bok);
        check("queued.accept_wait", wc, 0);
        check("queued.pull_cycles", cyc, 4);
        check("queued.pull_data", {8'd0, pull_data}, 32'h00000077);
        check("queued.sp", {24'd0, sp}, 32'h00000080);
        ref_pd = 24'h000077;

        // Randomized commands against the reference model.
        for (int t = 0; t < 150; t++) begin
            logic [1:0] rc;
            logic       rp;
            if ($urandom_range(0, 1) == 1) set_sp(8'($urandom));
            rp = 1'($urandom);
            rc = 2'($urandom_range(0, 3));
            exec_and_check($sformatf("rand%0d", t), rp, rc, 24'($urandom), 1'b1, cyc);
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
